dmem_ctrl: RTL and testbench

Data-memory controller and two-port arbiter for the four byte-lane data BRAM banks, `bram0`..`bram3`. Bank k holds byte lane k of each 32-bit word. The block shares the banks between the pipelined core (port C) and the firmware loader/debug master (port L). It translates byte, half and word loads and stores into per-lane bank enables, and returns sign- or zero-extended load data with a fixed one-cycle latency.

---
 rtl/dmem_pkg.sv | 34 +++
 rtl/dmem_if.sv | 42 ++++
 rtl/dmem_load_align.sv | 27 ++
 rtl/dmem_ctrl.sv | 127 ++++++++++++
 tb/tb_dmem_ctrl.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory controller: size encodings,
// lane-mask helper and the registered response record.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    localparam int RSP_DATA_W = 32;
    localparam int RSP_ERR_W  = 1;

    typedef struct packed {
        logic                  valid;
        logic [RSP_ERR_W-1:0]  err;
        logic [RSP_DATA_W-1:0] data;
    } rsp_t;

    // Bank lanes touched by an access of this size at lane offset off.
    function automatic logic [3:0] lane_mask(input size_e size,
                                             input logic [1:0] off);
        logic [3:0] m;
        unique case (size)
            SZ_BYTE: m = 4'b0001 << off;
            SZ_HALF: m = off[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: m = 4'b1111;
            SZ_ILL:  m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Bus bundle between the two requesters (C, L), the controller and
// the four byte-lane banks. slave = controller view, master = far side.
interface dmem_if #(
    parameter int ADDR_WIDTH = 13
) ();

    logic                  C_REQ,   L_REQ;
    logic                  C_WE,    L_WE;
    logic [1:0]            C_SIZE,  L_SIZE;
    logic                  C_UNS,   L_UNS;
    logic [ADDR_WIDTH-1:0] C_ADDR,  L_ADDR;
    logic [31:0]           C_WDATA, L_WDATA;
    logic                  C_GNT,   L_GNT;
    logic                  C_RVALID, L_RVALID;
    logic [31:0]           C_RDATA, L_RDATA;
    logic                  C_ERR,   L_ERR;

    logic [ADDR_WIDTH-1:0] B_ADDR;
    logic [3:0]            B_WE;
    logic [3:0]            B_RE;
    logic [31:0]           B_DIN;
    logic [31:0]           B_DOUT;

    modport slave (
        input  C_REQ, C_WE, C_SIZE, C_UNS, C_ADDR, C_WDATA,
        input  L_REQ, L_WE, L_SIZE, L_UNS, L_ADDR, L_WDATA,
        output C_GNT, C_RVALID, C_RDATA, C_ERR,
        output L_GNT, L_RVALID, L_RDATA, L_ERR,
        output B_ADDR, B_WE, B_RE, B_DIN,
        input  B_DOUT
    );

    modport master (
        output C_REQ, C_WE, C_SIZE, C_UNS, C_ADDR, C_WDATA,
        output L_REQ, L_WE, L_SIZE, L_UNS, L_ADDR, L_WDATA,
        input  C_GNT, C_RVALID, C_RDATA, C_ERR,
        input  L_GNT, L_RVALID, L_RDATA, L_ERR,
        input  B_ADDR, B_WE, B_RE, B_DIN,
        output B_DOUT
    );

endinterface

// File: rtl/dmem_load_align.sv
// Load formatter: picks the addressed lane(s) of B_DOUT, moves them
// to bit 0 and sign- or zero-extends. Ports: dout, size, off, uns -> data.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] dout,
    input  size_e       size,
    input  logic [1:0]  off,
    input  logic        uns,
    output logic [31:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b    = dout[{off, 3'b000} +: 8];
        h    = off[1] ? dout[31:16] : dout[15:0];
        data = dout;
        unique case (1'b1)
            size == SZ_BYTE: data = {{24{~uns & b[7]}}, b};
            size == SZ_HALF: data = {{16{~uns & h[15]}}, h};
            default:         data = dout;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Two-port (C/L) round-robin arbiter and byte-lane controller for the
// data BRAM banks. Ports: CLK, RST, bus (dmem_if.slave).
// Option: DMEM_MISALIGN_TRAP_EN makes misaligned/illegal accesses error.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 13
) (
    input  logic   CLK,
    input  logic   RST,
    dmem_if.slave  bus
);

    logic                  c_pri;
    logic                  c_gnt, l_gnt;
    logic                  sel_we, sel_uns;
    size_e                 sel_size;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [31:0]           sel_wdata;
    size_e                 eff_size;
    logic [1:0]            eff_off;
    logic                  acc_err;
    logic [3:0]            mask;
    logic [31:0]           ld_data;
    rsp_t                  rsp_d, c_rsp, l_rsp;

    // c_pri=1 means C wins a tie (L was granted last).
    always_comb begin
        c_gnt = 1'b0;
        l_gnt = 1'b0;
        if (!RST) begin
            c_gnt = bus.C_REQ && (!bus.L_REQ || c_pri);
            l_gnt = bus.L_REQ && !c_gnt;
        end
    end

    assign sel_we    = l_gnt ? bus.L_WE    : bus.C_WE;
    assign sel_uns   = l_gnt ? bus.L_UNS   : bus.C_UNS;
    assign sel_size  = size_e'(l_gnt ? bus.L_SIZE : bus.C_SIZE);
    assign sel_addr  = l_gnt ? bus.L_ADDR  : bus.C_ADDR;
    assign sel_wdata = l_gnt ? bus.L_WDATA : bus.C_WDATA;

    // Natural alignment is forced unless trapping; SIZE=11 acts as word.
    always_comb begin
        eff_size = sel_size;
        eff_off  = sel_addr[1:0];
        acc_err  = 1'b0;
        unique case (sel_size)
            SZ_BYTE: eff_off = sel_addr[1:0];
            SZ_HALF: begin
                eff_off = {sel_addr[1], 1'b0};
`ifdef DMEM_MISALIGN_TRAP_EN
                acc_err = sel_addr[0];
`endif
            end
            SZ_WORD: begin
                eff_off = 2'b00;
`ifdef DMEM_MISALIGN_TRAP_EN
                acc_err = |sel_addr[1:0];
`endif
            end
            SZ_ILL: begin
                eff_size = SZ_WORD;
                eff_off  = 2'b00;
`ifdef DMEM_MISALIGN_TRAP_EN
                acc_err  = 1'b1;
`endif
            end
        endcase
    end

    assign mask = ((c_gnt || l_gnt) && !acc_err)
                ? lane_mask(eff_size, eff_off) : 4'b0000;

    assign bus.B_WE   = sel_we ? mask : 4'b0000;
    assign bus.B_RE   = sel_we ? 4'b0000 : mask;
    assign bus.B_ADDR = {sel_addr[ADDR_WIDTH-1:2], 2'b00};

    always_comb begin
        unique case (1'b1)
            eff_size == SZ_BYTE: bus.B_DIN = {4{sel_wdata[7:0]}};
            eff_size == SZ_HALF: bus.B_DIN = {2{sel_wdata[15:0]}};
            default:             bus.B_DIN = sel_wdata;
        endcase
    end

    dmem_load_align u_align (
        .dout (bus.B_DOUT),
        .size (eff_size),
        .off  (eff_off),
        .uns  (sel_uns),
        .data (ld_data)
    );

    // B_DOUT is valid after the negedge, so the edge closing the
    // accepting cycle captures the formatted load directly.
    always_comb begin
        rsp_d.valid = 1'b1;
        rsp_d.err   = acc_err;
        rsp_d.data  = (sel_we || acc_err) ? '0 : ld_data;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            c_rsp <= '0;
            l_rsp <= '0;
            c_pri <= 1'b1;
        end else begin
            c_rsp <= c_gnt ? rsp_d : '0;
            l_rsp <= l_gnt ? rsp_d : '0;
            if (c_gnt)
                c_pri <= 1'b0;
            else if (l_gnt)
                c_pri <= 1'b1;
        end
    end

    assign bus.C_GNT    = c_gnt;
    assign bus.L_GNT    = l_gnt;
    assign bus.C_RVALID = c_rsp.valid;
    assign bus.L_RVALID = l_rsp.valid;
    assign bus.C_ERR    = c_rsp.err;
    assign bus.L_ERR    = l_rsp.err;
    assign bus.C_RDATA  = c_rsp.data;
    assign bus.L_RDATA  = l_rsp.data;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl with a behavioural byte-memory
// model and a negedge four-bank BRAM model.
module tb_dmem_ctrl;

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    dmem_if #(.ADDR_WIDTH(13)) bus ();

    dmem_ctrl #(.ADDR_WIDTH(13)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    // Bank model: four byte lanes, clocked on negedge, cleared in reset.
    logic [7:0]  bank [4][2048];
    logic [31:0] dout_r = '0;
    assign bus.B_DOUT = dout_r;

    always @(negedge clk) begin
        if (rst) begin
            for (int w = 0; w < 2048; w++)
                for (int k = 0; k < 4; k++)
                    bank[k][w] <= 8'h00;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (bus.B_WE[k])
                    bank[k][bus.B_ADDR[12:2]] <= bus.B_DIN[8*k +: 8];
                if (bus.B_RE[k])
                    dout_r[8*k +: 8] <= bank[k][bus.B_ADDR[12:2]];
            end
        end
    end

    // Reference model: plain byte-addressed memory.
    logic [7:0] ref_mem [8192];

    function automatic void model_clear();
        for (int i = 0; i < 8192; i++) ref_mem[i] = 8'h00;
    endfunction

    function automatic int nb(input logic [1:0] s);
        return (s == 2'd3) ? 4 : (1 << s);
    endfunction

    function automatic bit is_mis(input logic [1:0] s, input logic [12:0] a);
        return (s == 2'd3) || ((int'(a) % nb(s)) != 0);
    endfunction

    function automatic bit exp_err(input logic [1:0] s, input logic [12:0] a);
        return TRAP && is_mis(s, a);
    endfunction

    function automatic int base_of(input logic [1:0] s, input logic [12:0] a);
        return int'(a) - (int'(a) % nb(s));
    endfunction

    function automatic logic [3:0] exp_mask(input logic [1:0] s,
                                            input logic [12:0] a);
        if (exp_err(s, a)) return 4'b0000;
        return 4'(((1 << nb(s)) - 1) << (base_of(s, a) % 4));
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] s,
                                             input bit u,
                                             input logic [12:0] a);
        logic [31:0] v;
        int n, b;
        if (exp_err(s, a)) return 32'h0;
        n = nb(s);
        b = base_of(s, a);
        v = 32'h0;
        for (int i = 0; i < n; i++)
            v = v | (32'(ref_mem[b + i]) << (8 * i));
        if (!u && n < 4 && v[8*n-1])
            v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    function automatic void model_store(input logic [1:0] s,
                                        input logic [12:0] a,
                                        input logic [31:0] wd);
        int b;
        if (exp_err(s, a)) return;
        b = base_of(s, a);
        for (int i = 0; i < nb(s); i++)
            ref_mem[b + i] = wd[8*i +: 8];
    endfunction

    // Bus drivers (no checking here).
    task automatic idle();
        bus.C_REQ = 1'b0;
        bus.L_REQ = 1'b0;
    endtask

    task automatic drive(input bit port, input bit we, input logic [1:0] size,
                         input bit uns, input logic [12:0] addr,
                         input logic [31:0] wd);
        if (!port) begin
            bus.C_REQ = 1'b1; bus.C_WE = we; bus.C_SIZE = size;
            bus.C_UNS = uns;  bus.C_ADDR = addr; bus.C_WDATA = wd;
        end else begin
            bus.L_REQ = 1'b1; bus.L_WE = we; bus.L_SIZE = size;
            bus.L_UNS = uns;  bus.L_ADDR = addr; bus.L_WDATA = wd;
        end
    endtask

    // One lone-requester transaction, entered and left at posedge+1.
    task automatic txn(input bit port, input bit we, input logic [1:0] size,
                       input bit uns, input logic [12:0] addr,
                       input logic [31:0] wd,
                       output logic gnt, output logic [3:0] bwe,
                       output logic [3:0] bre, output logic [31:0] bdin,
                       output logic rv_own, output logic rv_oth,
                       output logic err, output logic [31:0] rdata);
        idle();
        drive(port, we, size, uns, addr, wd);
        #1;
        gnt  = port ? bus.L_GNT : bus.C_GNT;
        bwe  = bus.B_WE;
        bre  = bus.B_RE;
        bdin = bus.B_DIN;
        @(posedge clk);
        #1;
        idle();
        rv_own = port ? bus.L_RVALID : bus.C_RVALID;
        rv_oth = port ? bus.C_RVALID : bus.L_RVALID;
        err    = port ? bus.L_ERR    : bus.C_ERR;
        rdata  = port ? bus.L_RDATA  : bus.C_RDATA;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 2'd2, 0, 13'h010, 32'h0);
        drive(1, 0, 2'd2, 0, 13'h020, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({bus.C_GNT, bus.L_GNT} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_gnt: got %b want 00", {bus.C_GNT, bus.L_GNT});
        end
        n_tests++;
        if ({bus.B_WE, bus.B_RE} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_bank_en: got %h want 00", {bus.B_WE, bus.B_RE});
        end
        n_tests++;
        if ({bus.C_RVALID, bus.L_RVALID, bus.C_ERR, bus.L_ERR} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_rsp: got %b want 0000",
                     {bus.C_RVALID, bus.L_RVALID, bus.C_ERR, bus.L_ERR});
        end
        n_tests++;
        if ({bus.C_RDATA, bus.L_RDATA} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h/%h want 0", bus.C_RDATA, bus.L_RDATA);
        end
        idle();
        rst = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
    endtask

    task automatic test_word();
        logic g, rvo, rvx, e;
        logic [3:0] we_s, re_s;
        logic [31:0] din, rd;
        txn(0, 1, 2'd2, 0, 13'h010, 32'hDEAD_BEEF, g, we_s, re_s, din, rvo, rvx, e, rd);
        model_store(2'd2, 13'h010, 32'hDEAD_BEEF);
        n_tests++;
        if ({g, we_s, re_s} !== 9'b1_1111_0000) begin
            n_fail++;
            $display("FAIL word_store_en: got %b want 111110000", {g, we_s, re_s});
        end
        n_tests++;
        if ({rvo, rvx, rd} !== {2'b10, 32'h0}) begin
            n_fail++;
            $display("FAIL word_store_rsp: got %b %h want 10 0", {rvo, rvx}, rd);
        end
        txn(0, 0, 2'd2, 0, 13'h010, 32'h0, g, we_s, re_s, din, rvo, rvx, e, rd);
        n_tests++;
        if ({g, re_s, rvo, rvx} !== 7'b1_1111_10) begin
            n_fail++;
            $display("FAIL word_load_hs: got %b want 1111110", {g, re_s, rvo, rvx});
        end
        n_tests++;
        if (rd !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL word_load_data: got %h want deadbeef", rd);
        end
    endtask

    task automatic test_subword();
        logic g, rvo, rvx, e;
        logic [3:0] we_s, re_s;
        logic [31:0] din, rd;
        txn(0, 0, 2'd0, 0, 13'h013, 32'h0, g, we_s, re_s, din, rvo, rvx, e, rd);
        n_tests++;
        if ({re_s, rd} !== {4'b1000, 32'hFFFF_FFDE}) begin
            n_fail++;
            $display("FAIL lb_signed: got %b %h want 1000 ffffffde", re_s, rd);
        end
        txn(1, 0, 2'd0, 1, 13'h013, 32'h0, g, we_s, re_s, din, rvo, rvx, e, rd);
        n_tests++;
        if ({rvo, rvx, rd} !== {2'b10, 32'h0000_00DE}) begin
            n_fail++;
            $display("FAIL lbu_port_l: got %b %h want 10 000000de", {rvo, rvx}, rd);
        end
        txn(0, 0, 2'd1, 0, 13'h010, 32'h0, g, we_s, re_s, din, rvo, rvx, e, rd);
        n_tests++;
        if ({re_s, rd} !== {4'b0011, 32'hFFFF_BEEF}) begin
            n_fail++;
            $display("FAIL lh_signed: got %b %h want 0011 ffffbeef", re_s, rd);
        end
    endtask

    task automatic test_byte_store();
        logic g, rvo, rvx, e;
        logic [3:0] we_s, re_s;
        logic [31:0] din, rd;
        txn(0, 1, 2'd0, 0, 13'h011, 32'hAB_CD_EF_12, g, we_s, re_s, din, rvo, rvx, e, rd);
        model_store(2'd0, 13'h011, 32'hABCD_EF12);
        n_tests++;
        if ({we_s, din} !== {4'b0010, 32'h1212_1212}) begin
            n_fail++;
            $display("FAIL sb_lanes: got %b %h want 0010 12121212", we_s, din);
        end
        txn(0, 0, 2'd2, 0, 13'h010, 32'h0, g, we_s, re_s, din, rvo, rvx, e, rd);
        n_tests++;
        if (rd !== 32'hDEAD_12EF) begin
            n_fail++;
            $display("FAIL sb_readback: got %h want dead12ef", rd);
        end
    endtask

    task automatic test_misalign();
        logic g, rvo, rvx, e;
        logic [3:0] we_s, re_s;
        logic [31:0] din, rd, want;
        logic [3:0] want_re;
        want    = exp_load(2'd2, 0, 13'h012);
        want_re = exp_mask(2'd2, 13'h012);
        txn(0, 0, 2'd2, 0, 13'h012, 32'h0, g, we_s, re_s, din, rvo, rvx, e, rd);
        n_tests++;
        if ({g, re_s, rvo} !== {1'b1, want_re, 1'b1}) begin
            n_fail++;
            $display("FAIL misalign_en: got %b want %b", {g, re_s, rvo}, {1'b1, want_re, 1'b1});
        end
        n_tests++;
        if ({e, rd} !== {TRAP, want}) begin
            n_fail++;
            $display("FAIL misalign_rsp: got %b %h want %b %h", e, rd, TRAP, want);
        end
    endtask

    task automatic test_contention();
        logic g, rvo, rvx, e;
        logic [3:0] we_s, re_s;
        logic [31:0] din, rd, cw, lw;
        bit prio_c, win_c;
        txn(0, 1, 2'd2, 0, 13'h010, 32'h1122_3344, g, we_s, re_s, din, rvo, rvx, e, rd);
        model_store(2'd2, 13'h010, 32'h1122_3344);
        txn(1, 1, 2'd2, 0, 13'h020, 32'h5566_7788, g, we_s, re_s, din, rvo, rvx, e, rd);
        model_store(2'd2, 13'h020, 32'h5566_7788);
        cw = exp_load(2'd2, 0, 13'h010);
        lw = exp_load(2'd2, 0, 13'h020);
        prio_c = 1'b1;
        drive(0, 0, 2'd2, 0, 13'h010, 32'h0);
        drive(1, 0, 2'd2, 0, 13'h020, 32'h0);
        for (int i = 0; i < 4; i++) begin
            #1;
            win_c  = prio_c;
            prio_c = !prio_c;
            n_tests++;
            if ({bus.C_GNT, bus.L_GNT} !== {win_c, !win_c}) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got %b want %b", i,
                         {bus.C_GNT, bus.L_GNT}, {win_c, !win_c});
            end
            @(posedge clk);
            #1;
            n_tests++;
            if ({bus.C_RVALID, bus.L_RVALID} !== {win_c, !win_c}) begin
                n_fail++;
                $display("FAIL rr_rvalid[%0d]: got %b want %b", i,
                         {bus.C_RVALID, bus.L_RVALID}, {win_c, !win_c});
            end
            n_tests++;
            if ((win_c ? bus.C_RDATA : bus.L_RDATA) !== (win_c ? cw : lw)) begin
                n_fail++;
                $display("FAIL rr_rdata[%0d]: got %h want %h", i,
                         win_c ? bus.C_RDATA : bus.L_RDATA, win_c ? cw : lw);
            end
        end
        idle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        drive(0, 0, 2'd2, 0, 13'h010, 32'h0);
        #1;
        n_tests++;
        if (bus.C_GNT !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_accept: got %b want 1", bus.C_GNT);
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        drive(1, 0, 2'd2, 0, 13'h020, 32'h0);
        @(posedge clk);
        #1;
        n_tests++;
        if ({bus.C_RVALID, bus.L_RVALID} !== 2'b00) begin
            n_fail++;
            $display("FAIL rstmid_drop: got %b want 00", {bus.C_RVALID, bus.L_RVALID});
        end
        n_tests++;
        if ({bus.C_GNT, bus.L_GNT, bus.B_RE} !== 6'b0) begin
            n_fail++;
            $display("FAIL rstmid_gnt: got %b want 000000",
                     {bus.C_GNT, bus.L_GNT, bus.B_RE});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        #1;
        n_tests++;
        if ({bus.C_GNT, bus.L_GNT} !== 2'b10) begin
            n_fail++;
            $display("FAIL rstmid_ptr: got %b want 10", {bus.C_GNT, bus.L_GNT});
        end
        idle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        bit pend = 0;
        bit p_port, port, we, uns;
        logic [1:0]  size;
        logic [12:0] addr;
        logic [31:0] wd, p_rd, m32, want_din;
        logic [3:0]  m;
        bit p_err;
        for (int i = 0; i <= 300; i++) begin
            if (pend) begin
                n_tests++;
                if ({bus.C_RVALID, bus.L_RVALID} !== {!p_port, p_port}) begin
                    n_fail++;
                    $display("FAIL b2b_rvalid[%0d]: got %b want %b", i,
                             {bus.C_RVALID, bus.L_RVALID}, {!p_port, p_port});
                end
                n_tests++;
                if ((p_port ? bus.L_RDATA : bus.C_RDATA) !== p_rd ||
                    (p_port ? bus.L_ERR : bus.C_ERR) !== p_err) begin
                    n_fail++;
                    $display("FAIL b2b_rsp[%0d]: got %h/%b want %h/%b", i,
                             p_port ? bus.L_RDATA : bus.C_RDATA,
                             p_port ? bus.L_ERR : bus.C_ERR, p_rd, p_err);
                end
            end
            if (i == 300) break;
            port = 1'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            uns  = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3));
            addr = 13'($urandom_range(0, 63));
            wd   = $urandom;
            idle();
            drive(port, we, size, uns, addr, wd);
            #1;
            m = exp_mask(size, addr);
            n_tests++;
            if ({bus.C_GNT, bus.L_GNT} !== {!port, port} ||
                bus.B_WE !== (we ? m : 4'b0) || bus.B_RE !== (we ? 4'b0 : m)) begin
                n_fail++;
                $display("FAIL b2b_en[%0d]: got %b %b %b want %b %b %b", i,
                         {bus.C_GNT, bus.L_GNT}, bus.B_WE, bus.B_RE,
                         {!port, port}, we ? m : 4'b0, we ? 4'b0 : m);
            end
            if (we && m != 4'b0) begin
                m32 = '0;
                want_din = '0;
                for (int k = 0; k < 4; k++) begin
                    if (m[k]) begin
                        m32[8*k +: 8] = 8'hFF;
                        want_din[8*k +: 8] =
                            wd[8*(k - base_of(size, addr) % 4) +: 8];
                    end
                end
                n_tests++;
                if ((bus.B_DIN & m32) !== want_din) begin
                    n_fail++;
                    $display("FAIL b2b_din[%0d]: got %h want %h", i,
                             bus.B_DIN & m32, want_din);
                end
            end
            p_port = port;
            p_err  = exp_err(size, addr);
            p_rd   = we ? 32'h0 : exp_load(size, uns, addr);
            if (we) model_store(size, addr, wd);
            pend = 1;
            @(posedge clk);
            #1;
        end
        idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        bus.C_WE = 0; bus.C_SIZE = 0; bus.C_UNS = 0; bus.C_ADDR = 0; bus.C_WDATA = 0;
        bus.L_WE = 0; bus.L_SIZE = 0; bus.L_UNS = 0; bus.L_ADDR = 0; bus.L_WDATA = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_word();
        test_subword();
        test_byte_store();
        test_misalign();
        test_contention();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
